// File: rtl/hdmi_tmds_pkg.sv
// Shared constants, types and helpers for the HDMI/DVI TMDS encoder.
package hdmi_tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_LANE0 = 10'b1011001100;
    localparam logic [9:0] GUARD_LANE1 = 10'b0100110011;
    localparam logic [9:0] GUARD_LANE2 = 10'b1011001100;

    localparam logic [9:0] CLK_WORD_DEFAULT = 10'b1111100000;

    typedef enum logic [1:0] {
        CONTROL  = 2'd0,
        PREAMBLE = 2'd1,
        GUARD    = 2'd2,
        VIDEO    = 2'd3
    } slot_t;

    typedef struct packed {
        logic       de;
        logic       hdmi_en;
        logic       hsync;
        logic       vsync;
        logic [7:0] blue;
        logic [7:0] green;
        logic [7:0] red;
    } pix_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        popcount8 = '0;
        for (int i = 0; i < 8; i++) popcount8 += {3'b000, v[i]};
    endfunction

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   ctrl_token = CTRL_00;
            2'b01:   ctrl_token = CTRL_01;
            2'b10:   ctrl_token = CTRL_10;
            default: ctrl_token = CTRL_11;
        endcase
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: 8b/10b video coding with running disparity, control tokens
// and guard-band words, all registered.
module tmds_lane_enc
    import hdmi_tmds_pkg::*;
(
    input  logic       pixelclk,
    input  logic       rstin_n,
    input  slot_t      slot,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    input  logic [9:0] guard_word,
    output logic [9:0] dout
);

    // Transition-minimised word; bit 8 is 1 for XOR, 0 for XNOR.
    function automatic logic [8:0] tm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        n1 = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        tm_encode[0] = d[0];
        for (int i = 1; i < 8; i++)
            tm_encode[i] = tm_encode[i-1] ^ d[i] ^ use_xnor;
        tm_encode[8] = ~use_xnor;
    endfunction

    logic        [8:0] q_m;
    logic        [3:0] n1q;
    logic signed [4:0] bal;
    logic signed [4:0] cnt, cnt_next;
    logic        [9:0] video_q, dout_next;

    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        q_m      = tm_encode(din);
        n1q      = popcount8(q_m[7:0]);
        bal      = $signed({n1q, 1'b0} - 5'd8);
        video_q  = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_next = q_m[8] ? cnt + bal : cnt - bal;

        if ((cnt != 5'sd0) && (n1q != 4'd4)) begin
            if ((!cnt[4] && (n1q > 4'd4)) || (cnt[4] && (n1q < 4'd4))) begin
                video_q  = {1'b1, q_m[8], ~q_m[7:0]};
                cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - bal;
            end else begin
                video_q  = {1'b0, q_m[8], q_m[7:0]};
                cnt_next = cnt - (q_m[8] ? 5'sd0 : 5'sd2) + bal;
            end
        end

        dout_next = ctrl_token(c1, c0);
        unique case (slot)
            VIDEO:    dout_next = video_q;
            GUARD:    dout_next = guard_word;
            default:  dout_next = ctrl_token(c1, c0);
        endcase
    end

    // NOTE: non-blocking assignments so every register samples last cycle's values.
    always_ff @(posedge pixelclk or negedge rstin_n) begin
        if (!rstin_n) begin
            dout <= CTRL_00;
            cnt  <= '0;
        end else begin
            dout <= dout_next;
            cnt  <= (slot == VIDEO) ? cnt_next : 5'sd0;
        end
    end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Three-lane TMDS encoder with HDMI video preamble / guard-band framing,
// driven by a de lookahead delay line.
module hdmi_tmds_encoder
    import hdmi_tmds_pkg::*;
#(
    parameter int         HDMI_MODE = 1,
    parameter int         LOOKAHEAD = 10,
    parameter logic [9:0] CLK_WORD  = CLK_WORD_DEFAULT,
    parameter int         LSB_FIRST = 1
) (
    input  logic       pixelclk,
    input  logic       rstin_n,
    input  logic       hdmi_en,
    input  logic [7:0] blue_din,
    input  logic [7:0] green_din,
    input  logic [7:0] red_din,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       de,
    output logic [9:0] tmds_data0,
    output logic [9:0] tmds_data1,
    output logic [9:0] tmds_data2,
    output logic [9:0] tmds_clk
);

    if ((HDMI_MODE != 0) && (LOOKAHEAD < 10)) begin : g_lookahead_check
        $error("LOOKAHEAD must be at least 10 when HDMI_MODE=1");
    end

    function automatic logic [9:0] bit_order(input logic [9:0] w);
        for (int i = 0; i < 10; i++)
            bit_order[i] = (LSB_FIRST != 0) ? w[i] : w[9-i];
    endfunction

    pix_t             din_pix;
    pix_t             dly [LOOKAHEAD];
    pix_t             cur;
    logic [LOOKAHEAD:1] ahead;
    logic             framing, near, far;
    slot_t            slot;
    logic [9:0]       lane0_q, lane1_q, lane2_q;

    assign din_pix = {de, hdmi_en, hsync, vsync, blue_din, green_din, red_din};

    // NOTE: the delay line is reset like any other register so no stale pixel survives a reset.
    always_ff @(posedge pixelclk or negedge rstin_n) begin
        if (!rstin_n) begin
            for (int i = 0; i < LOOKAHEAD; i++) dly[i] <= '0;
        end else begin
            dly[0] <= din_pix;
            for (int i = 1; i < LOOKAHEAD; i++) dly[i] <= dly[i-1];
        end
    end

    // ahead[k] is the de that becomes current k cycles from now.
    for (genvar k = 1; k < LOOKAHEAD; k++) begin : g_ahead
        assign ahead[k] = dly[LOOKAHEAD-1-k].de;
    end
    assign ahead[LOOKAHEAD] = de;

    always_comb begin
        cur     = dly[LOOKAHEAD-1];
        framing = (HDMI_MODE != 0) && cur.hdmi_en;
        near    = ahead[1] | ahead[2];
        far     = 1'b0;
        for (int k = 3; k <= 10; k++)
            if (k <= LOOKAHEAD) far = far | ahead[k];

        if (cur.de)                slot = VIDEO;
        else if (framing && near)  slot = GUARD;
        else if (framing && far)   slot = PREAMBLE;
        else                       slot = CONTROL;
    end

    tmds_lane_enc u_lane0 (
        .pixelclk   (pixelclk),
        .rstin_n    (rstin_n),
        .slot       (slot),
        .din        (cur.blue),
        .c0         (cur.hsync),
        .c1         (cur.vsync),
        .guard_word (GUARD_LANE0),
        .dout       (lane0_q)
    );

    // Lane 1 carries CTL0=1 during the video preamble.
    tmds_lane_enc u_lane1 (
        .pixelclk   (pixelclk),
        .rstin_n    (rstin_n),
        .slot       (slot),
        .din        (cur.green),
        .c0         (slot == PREAMBLE),
        .c1         (1'b0),
        .guard_word (GUARD_LANE1),
        .dout       (lane1_q)
    );

    tmds_lane_enc u_lane2 (
        .pixelclk   (pixelclk),
        .rstin_n    (rstin_n),
        .slot       (slot),
        .din        (cur.red),
        .c0         (1'b0),
        .c1         (1'b0),
        .guard_word (GUARD_LANE2),
        .dout       (lane2_q)
    );

    always_ff @(posedge pixelclk or negedge rstin_n) begin
        if (!rstin_n) begin
            tmds_data0 <= bit_order(CTRL_00);
            tmds_data1 <= bit_order(CTRL_00);
            tmds_data2 <= bit_order(CTRL_00);
        end else begin
            tmds_data0 <= bit_order(lane0_q);
            tmds_data1 <= bit_order(lane1_q);
            tmds_data2 <= bit_order(lane2_q);
        end
    end

    assign tmds_clk = bit_order(CLK_WORD);

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Directed bench for hdmi_tmds_encoder: reset, TMDS disparity, HDMI framing,
// short gaps, framing disabled, DVI instance and mid-line reset.
module tb_hdmi_tmds_encoder;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] G0  = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;
    localparam logic [9:0] G2  = 10'b1011001100;
    localparam logic [9:0] CLKW = 10'b1111100000;
    // Input sampled at edge i (12 register stages) is visible after edge i+11.
    localparam int OFS = 11;

    logic       pixelclk = 1'b0;
    logic       rstin_n;
    logic       hdmi_en, hsync, vsync, de;
    logic [7:0] blue_din, green_din, red_din;
    logic [9:0] tmds_data0, tmds_data1, tmds_data2, tmds_clk;
    logic [9:0] dvi_data0, dvi_data1, dvi_data2, dvi_clk;

    logic [9:0] cap0 [0:127];
    logic [9:0] cap1 [0:127];
    logic [9:0] cap2 [0:127];
    logic [9:0] capd1 [0:127];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int base;

    always #5 pixelclk = ~pixelclk;

    hdmi_tmds_encoder dut (
        .pixelclk   (pixelclk),
        .rstin_n    (rstin_n),
        .hdmi_en    (hdmi_en),
        .blue_din   (blue_din),
        .green_din  (green_din),
        .red_din    (red_din),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .tmds_data0 (tmds_data0),
        .tmds_data1 (tmds_data1),
        .tmds_data2 (tmds_data2),
        .tmds_clk   (tmds_clk)
    );

    hdmi_tmds_encoder #(.HDMI_MODE(0)) dut_dvi (
        .pixelclk   (pixelclk),
        .rstin_n    (rstin_n),
        .hdmi_en    (hdmi_en),
        .blue_din   (blue_din),
        .green_din  (green_din),
        .red_din    (red_din),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .tmds_data0 (dvi_data0),
        .tmds_data1 (dvi_data1),
        .tmds_data2 (dvi_data2),
        .tmds_clk   (dvi_clk)
    );

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic d, input logic he, input logic hs, input logic vs,
                         input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        @(negedge pixelclk);
        de = d; hdmi_en = he; hsync = hs; vsync = vs;
        blue_din = b; green_din = g; red_din = r;
        @(posedge pixelclk);
        #1;
        cap0[cyc]  = tmds_data0;
        cap1[cyc]  = tmds_data1;
        cap2[cyc]  = tmds_data2;
        capd1[cyc] = dvi_data1;
        cyc++;
    endtask

    initial begin
        rstin_n = 1'b0;
        de = 1'b0; hdmi_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
        blue_din = '0; green_din = '0; red_din = '0;
        #23;
        check("rst_lane0", tmds_data0, T00);
        check("rst_lane1", tmds_data1, T00);
        check("rst_lane2", tmds_data2, T00);
        check("rst_clk",   tmds_clk,   CLKW);
        @(posedge pixelclk);
        #2 rstin_n = 1'b1;

        // Line 1 after 20 blanking cycles: inputs 0..19 blank, 20..21 video.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++)  cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h55);
        // 4-cycle gap (22..25), line 2 (26..27), 1-cycle gap (28), line 3 (29..30).
        for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++)  cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h55);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++)  cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h55);
        // Blanking with framing disabled (31..50), then video (51..62).
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h55);
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 8'hAA, 8'hAA);

        check("flushed_lane0",   cap0[5],  T00);
        check("first_ctl_lane0", cap0[0+OFS], T01);
        check("pre_ctl_lane1",   cap1[20], T00);
        check("pre_first_lane0", cap0[21], T01);
        check("pre_first_lane1", cap1[21], T01);
        check("pre_first_lane2", cap2[21], T00);
        check("pre_last_lane1",  cap1[28], T01);
        check("guard_a_lane0",   cap0[29], G0);
        check("guard_a_lane1",   cap1[29], G1);
        check("guard_a_lane2",   cap2[29], G2);
        check("guard_b_lane1",   cap1[30], G1);
        check("video0_lane0",    cap0[31], 10'b0100000000);
        check("video0_lane1",    cap1[31], 10'b1000000000);
        check("video0_lane2",    cap2[31], 10'b0100110011);
        check("video1_lane0",    cap0[32], 10'b1111111111);
        check("video1_lane1",    cap1[32], 10'b0011111111);
        check("gap4_pre_a",      cap1[33], T01);
        check("gap4_pre_b",      cap1[34], T01);
        check("gap4_guard_a",    cap1[35], G1);
        check("gap4_guard_b",    cap1[36], G1);
        check("line2_cnt0",      cap1[37], 10'b1000000000);
        check("line2_second",    cap1[38], 10'b0011111111);
        check("gap1_guard_l0",   cap0[39], G0);
        check("gap1_guard_l1",   cap1[39], G1);
        check("line3_cnt0",      cap1[40], 10'b1000000000);
        check("dvi_no_pre",      capd1[21], T00);
        check("dvi_no_guard",    capd1[29], T00);
        check("dvi_video0",      capd1[31], 10'b1000000000);
        check("dvi_gap4",        capd1[35], T00);
        check("off_slot_m10",    cap1[52], T00);
        check("off_slot_m2",     cap1[60], T00);
        check("off_slot_m1",     cap1[61], T00);
        check("off_slot_m1_l0",  cap0[61], T01);
        check("off_video0",      cap1[62], 10'b1000000000);

        // Reset mid-line with video in the pipeline.
        #2;
        rstin_n = 1'b0;
        de = 1'b0; hdmi_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
        blue_din = '0; green_din = '0; red_din = '0;
        #1;
        check("midrst_lane0", tmds_data0, T00);
        check("midrst_lane1", tmds_data1, T00);
        check("midrst_lane2", tmds_data2, T00);
        check("midrst_clk",   tmds_clk,   CLKW);
        repeat (2) @(posedge pixelclk);
        #2 rstin_n = 1'b1;

        base = cyc;
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        for (int k = 0; k < 12; k++) begin
            check($sformatf("post_rst_l0_%0d", k), cap0[base+k], T00);
            check($sformatf("post_rst_l1_%0d", k), cap1[base+k], T00);
            check($sformatf("post_rst_l2_%0d", k), cap2[base+k], T00);
        end
        check("token_vsync",      cap0[base+12+OFS], T10);
        check("token_vsync_hsync", cap0[base+13+OFS], T11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
